// File: rtl/csi_uport_axil_csr.sv
// AXI4-Lite CSR block for the CSI user-port traffic generator: destination IDs,
// initial credits, seeds, control levels/pulses and busy status.
module csi_uport_axil_csr #(
    parameter int ADDR_W       = 8,
    parameter int DST_W        = 4,
    parameter int CRD_W        = 12,
    parameter int NPR_DST_RST  = 0,
    parameter int CMPL_DST_RST = 1,
    parameter int PR_DST_RST   = 2
) (
    input  logic              user_clk,
    input  logic              user_reset,
    input  logic [ADDR_W-1:0] s_axil_awaddr,
    input  logic              s_axil_awvalid,
    output logic              s_axil_awready,
    input  logic [31:0]       s_axil_wdata,
    input  logic [3:0]        s_axil_wstrb,
    input  logic              s_axil_wvalid,
    output logic              s_axil_wready,
    output logic [1:0]        s_axil_bresp,
    output logic              s_axil_bvalid,
    input  logic              s_axil_bready,
    input  logic [ADDR_W-1:0] s_axil_araddr,
    input  logic              s_axil_arvalid,
    output logic              s_axil_arready,
    output logic [31:0]       s_axil_rdata,
    output logic [1:0]        s_axil_rresp,
    output logic              s_axil_rvalid,
    input  logic              s_axil_rready,
    output logic [DST_W-1:0]  npr_dst_id,
    output logic [DST_W-1:0]  cmpl_dst_id,
    output logic [DST_W-1:0]  pr_dst_id,
    output logic [CRD_W-1:0]  npr_init_crd,
    output logic [CRD_W-1:0]  cmpl_init_crd,
    output logic [CRD_W-1:0]  pr_init_crd,
    output logic [31:0]       pr_seed0,
    output logic [31:0]       pr_seed1,
    output logic [31:0]       cmpl_seed0,
    output logic [31:0]       cmpl_seed1,
    output logic              cmpl_en,
    output logic              cnt_rst,
    output logic              gen_rst,
    output logic              npr_start,
    output logic              pr_start,
    output logic [2:0]        ld_crd,
    input  logic              npr_busy,
    input  logic              cmpl_busy,
    input  logic              pr_busy
);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int NWORDS = 1 << IDX_W;
    localparam int CTRL_W = 10;

    localparam logic [IDX_W-1:0] A_NPR_DST   = IDX_W'(0);
    localparam logic [IDX_W-1:0] A_CMPL_DST  = IDX_W'(1);
    localparam logic [IDX_W-1:0] A_PR_DST    = IDX_W'(2);
    localparam logic [IDX_W-1:0] A_NPR_CRD   = IDX_W'(3);
    localparam logic [IDX_W-1:0] A_CMPL_CRD  = IDX_W'(4);
    localparam logic [IDX_W-1:0] A_PR_CRD    = IDX_W'(5);
    localparam logic [IDX_W-1:0] A_PR_SEED0  = IDX_W'(6);
    localparam logic [IDX_W-1:0] A_PR_SEED1  = IDX_W'(7);
    localparam logic [IDX_W-1:0] A_STATUS    = IDX_W'(9);
    localparam logic [IDX_W-1:0] A_CTRL      = IDX_W'(10);
    localparam logic [IDX_W-1:0] A_CM_SEED0  = IDX_W'(11);
    localparam logic [IDX_W-1:0] A_CM_SEED1  = IDX_W'(12);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [DST_W-1:0]  npr_dst_reg, cmpl_dst_reg, pr_dst_reg;
    logic [CRD_W-1:0]  npr_crd_reg, cmpl_crd_reg, pr_crd_reg;
    logic [31:0]       pr_seed0_reg, pr_seed1_reg, cmpl_seed0_reg, cmpl_seed1_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic              start_err_reg;
    logic              npr_start_reg, pr_start_reg;
    logic [2:0]        ld_crd_reg;

    logic              aw_held_reg, w_held_reg;
    logic [IDX_W-1:0]  aw_idx_reg;
    logic [31:0]       w_data_reg;
    logic [3:0]        w_strb_reg;
    logic              bvalid_reg, rvalid_reg;
    logic [1:0]        bresp_reg, rresp_reg;
    logic [31:0]       rdata_reg;

    logic [31:0]       reg_words [NWORDS];
    logic [NWORDS-1:0] map_ok;
    logic [31:0]       wr_old, wr_val;
    logic [CTRL_W-1:0] ctrl_rise;
    logic [IDX_W-1:0]  ar_idx;
    logic              commit;
    logic              unused_addr_lsbs;

    assign unused_addr_lsbs = ^{s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Word view of every register; unmapped slots read as zero.
    always_comb begin
        for (int i = 0; i < NWORDS; i++) reg_words[i] = '0;
        reg_words[0]  = 32'(npr_dst_reg);
        reg_words[1]  = 32'(cmpl_dst_reg);
        reg_words[2]  = 32'(pr_dst_reg);
        reg_words[3]  = 32'(npr_crd_reg);
        reg_words[4]  = 32'(cmpl_crd_reg);
        reg_words[5]  = 32'(pr_crd_reg);
        reg_words[6]  = pr_seed0_reg;
        reg_words[7]  = pr_seed1_reg;
        reg_words[9]  = {23'b0, start_err_reg, 5'b0, pr_busy, cmpl_busy, npr_busy};
        reg_words[10] = 32'(ctrl_reg);
        reg_words[11] = cmpl_seed0_reg;
        reg_words[12] = cmpl_seed1_reg;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NWORDS; gi++) begin : g_map
            assign map_ok[gi] = (gi <= 12) && (gi != 8);
        end
        for (gi = 0; gi < 4; gi++) begin : g_strb
            assign wr_val[8*gi +: 8] = w_strb_reg[gi] ? w_data_reg[8*gi +: 8] : wr_old[8*gi +: 8];
        end
    endgenerate

    assign wr_old    = reg_words[aw_idx_reg];
    assign ctrl_rise = wr_val[CTRL_W-1:0] & ~ctrl_reg;
    assign ar_idx    = s_axil_araddr[ADDR_W-1:2];
    assign commit    = aw_held_reg && w_held_reg;

    assign s_axil_awready = !aw_held_reg && !bvalid_reg;
    assign s_axil_wready  = !w_held_reg && !bvalid_reg;
    assign s_axil_arready = !rvalid_reg;

    always_ff @(posedge user_clk) begin
        if (user_reset) begin
            npr_dst_reg    <= DST_W'(NPR_DST_RST);
            cmpl_dst_reg   <= DST_W'(CMPL_DST_RST);
            pr_dst_reg     <= DST_W'(PR_DST_RST);
            npr_crd_reg    <= '0;
            cmpl_crd_reg   <= '0;
            pr_crd_reg     <= '0;
            pr_seed0_reg   <= '0;
            pr_seed1_reg   <= '0;
            cmpl_seed0_reg <= '0;
            cmpl_seed1_reg <= '0;
            ctrl_reg       <= '0;
            start_err_reg  <= 1'b0;
            npr_start_reg  <= 1'b0;
            pr_start_reg   <= 1'b0;
            ld_crd_reg     <= '0;
            aw_held_reg    <= 1'b0;
            w_held_reg     <= 1'b0;
            aw_idx_reg     <= '0;
            w_data_reg     <= '0;
            w_strb_reg     <= '0;
            bvalid_reg     <= 1'b0;
            bresp_reg      <= RESP_OKAY;
            rvalid_reg     <= 1'b0;
            rresp_reg      <= RESP_OKAY;
            rdata_reg      <= '0;
        end else begin
            npr_start_reg <= 1'b0;
            pr_start_reg  <= 1'b0;
            ld_crd_reg    <= '0;

            if (s_axil_awvalid && s_axil_awready) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_axil_awaddr[ADDR_W-1:2];
            end
            if (s_axil_wvalid && s_axil_wready) begin
                w_held_reg <= 1'b1;
                w_data_reg <= s_axil_wdata;
                w_strb_reg <= s_axil_wstrb;
            end

            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= map_ok[aw_idx_reg] ? RESP_OKAY : RESP_SLVERR;
                case (aw_idx_reg)
                    A_NPR_DST:  npr_dst_reg    <= wr_val[DST_W-1:0];
                    A_CMPL_DST: cmpl_dst_reg   <= wr_val[DST_W-1:0];
                    A_PR_DST:   pr_dst_reg     <= wr_val[DST_W-1:0];
                    A_NPR_CRD:  npr_crd_reg    <= wr_val[CRD_W-1:0];
                    A_CMPL_CRD: cmpl_crd_reg   <= wr_val[CRD_W-1:0];
                    A_PR_CRD:   pr_crd_reg     <= wr_val[CRD_W-1:0];
                    A_PR_SEED0: pr_seed0_reg   <= wr_val;
                    A_PR_SEED1: pr_seed1_reg   <= wr_val;
                    A_CM_SEED0: cmpl_seed0_reg <= wr_val;
                    A_CM_SEED1: cmpl_seed1_reg <= wr_val;
                    A_STATUS: begin
                        if (w_data_reg[8]) start_err_reg <= 1'b0;
                    end
                    A_CTRL: begin
                        ctrl_reg      <= wr_val[CTRL_W-1:0];
                        npr_start_reg <= ctrl_rise[0] && !npr_busy;
                        pr_start_reg  <= ctrl_rise[2] && !pr_busy;
                        ld_crd_reg    <= ctrl_rise[5:3];
                        // A start requested while the generator is busy is dropped and flagged.
                        if ((ctrl_rise[0] && npr_busy) || (ctrl_rise[2] && pr_busy))
                            start_err_reg <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (bvalid_reg && s_axil_bready) begin
                bvalid_reg <= 1'b0;
            end

            if (s_axil_arvalid && s_axil_arready) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= map_ok[ar_idx] ? reg_words[ar_idx] : 32'h0;
                rresp_reg  <= map_ok[ar_idx] ? RESP_OKAY : RESP_SLVERR;
            end else if (rvalid_reg && s_axil_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

    assign s_axil_bvalid = bvalid_reg;
    assign s_axil_bresp  = bresp_reg;
    assign s_axil_rvalid = rvalid_reg;
    assign s_axil_rresp  = rresp_reg;
    assign s_axil_rdata  = rdata_reg;

    assign npr_dst_id    = npr_dst_reg;
    assign cmpl_dst_id   = cmpl_dst_reg;
    assign pr_dst_id     = pr_dst_reg;
    assign npr_init_crd  = npr_crd_reg;
    assign cmpl_init_crd = cmpl_crd_reg;
    assign pr_init_crd   = pr_crd_reg;
    assign pr_seed0      = pr_seed0_reg;
    assign pr_seed1      = pr_seed1_reg;
    assign cmpl_seed0    = cmpl_seed0_reg;
    assign cmpl_seed1    = cmpl_seed1_reg;
    assign cmpl_en       = ctrl_reg[1];
    assign cnt_rst       = ctrl_reg[8];
    assign gen_rst       = ctrl_reg[9];
    assign npr_start     = npr_start_reg;
    assign pr_start      = pr_start_reg;
    assign ld_crd        = ld_crd_reg;
endmodule
